booth_r4_seq_mult: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier that generalises the existing combinational radix-4 partial-product multiplier.
- Retires one Booth digit per clock, giving a small area footprint.
- Supports signed and unsigned operands, selected per transaction.
- Uses valid/ready handshakes on input and output, so it drops into datapath pipelines that have back-pressure.

---
 rtl/booth_r4_pkg.sv | 34 +++
 rtl/booth_r4_digit_enc.sv | 37 +++
 rtl/booth_r4_seq_mult.sv | 104 ++++++++++
 tb/tb_booth_r4_seq_mult.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier family.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package booth_r4_pkg;

    // Signed Booth digit selected by one overlapping 3-bit window of the multiplier
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } booth_state_t;

    // Window {y[2i+1], y[2i], y[2i-1]} -> digit in {-2,-1,0,+1,+2}
    function automatic booth_digit_t booth_decode(input logic [2:0] triple);
        booth_digit_t d;
        case (triple)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Booth digit encoder: turns a 3-bit multiplier window and M into digit*M.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports:
//   triple : {y[2i+1], y[2i], y[2i-1]}
//   m      : multiplicand already extended to WIDTH+2 bits (two's complement)
//   pp     : digit*M as a WIDTH+3 bit two's-complement value
module booth_r4_digit_enc
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       triple,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] m_ext;
    logic [WIDTH+2:0] m_dbl;

    // WIDTH+3 bits holds +-2M even for a zero-extended unsigned M
    assign m_ext = {m[WIDTH+1], m};
    assign m_dbl = {m, 1'b0};

    always_comb begin
        pp = '0;
        case (booth_decode(triple))
            POS1:    pp = m_ext;
            POS2:    pp = m_dbl;
            NEG1:    pp = -m_ext;
            NEG2:    pp = -m_dbl;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned per transaction.
// Latency: result valid WIDTH/2+1 cycles after the acceptance edge, independent of data.
// Backpressure: in_ready low while busy or holding a result; result held until out_ready.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake; x, y, signed_mode sampled on acceptance
//   out_valid/out_ready   : result handshake; out_o holds the 2*WIDTH product
module booth_r4_seq_mult
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_o
);

    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int PW    = 2 * WIDTH;

    booth_state_t      state;
    logic [WIDTH+1:0]  m_reg;
    // Multiplier with the implicit y[-1]=0 appended; shifted right two bits per digit
    logic [WIDTH+2:0]  y_sh;
    logic [PW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;

    logic [WIDTH+2:0]  pp;
    logic [PW-1:0]     pp_ext;
    logic [PW-1:0]     acc_nxt;
    logic [WIDTH+1:0]  x_ext;
    logic [WIDTH+1:0]  y_ext;

    assign x_ext = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign y_ext = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    booth_r4_digit_enc #(.WIDTH(WIDTH)) u_enc (
        .triple (y_sh[2:0]),
        .m      (m_reg),
        .pp     (pp)
    );

    // Partial product weighted by 4^cnt; wraparound beyond PW bits is intended
    assign pp_ext  = {{(PW - WIDTH - 3){pp[WIDTH+2]}}, pp};
    assign acc_nxt = acc + (pp_ext << {cnt, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_o     <= '0;
            m_reg     <= '0;
            y_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        m_reg    <= x_ext;
                        y_sh     <= {y_ext, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    acc  <= acc_nxt;
                    y_sh <= y_sh >> 2;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NDIG - 1)) begin
                        state     <= DONE;
                        out_o     <= acc_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench: directed cases at WIDTH=16, then randomized traffic at WIDTH=16 and WIDTH=8
// checked against an arithmetic reference product.
module tb_booth_r4_seq_mult;

    logic clk;
    logic rst_n;

    // WIDTH=16 instance
    logic        iv16, ir16, sm16, ov16, or16;
    logic [15:0] x16, y16;
    logic [31:0] o16;

    // WIDTH=8 instance
    logic        iv8, ir8, sm8, ov8, or8;
    logic [7:0]  x8, y8;
    logic [15:0] o8;

    int n_tests = 0;
    int n_fail  = 0;

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16), .signed_mode(sm16),
        .out_valid(ov16), .out_ready(or16), .out_o(o16)
    );

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8), .out_o(o8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product: plain integer multiply of the extended operands, truncated to 2w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm, input int w);
        logic [63:0] ta, tb;
        longint sa, sb, p;
        ta = {32'b0, a} << (64 - w);
        tb = {32'b0, b} << (64 - w);
        if (sm) begin
            sa = signed'(ta) >>> (64 - w);
            sb = signed'(tb) >>> (64 - w);
        end else begin
            sa = longint'(ta >> (64 - w));
            sb = longint'(tb >> (64 - w));
        end
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One WIDTH=16 transaction with out_ready held high once the result appears
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        output logic [31:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!ir16 && guard < 50) begin @(negedge clk); guard++; end
        if (guard == 50) check("op16_ready_timeout", 64'(guard), 64'd0);
        iv16 = 1'b1; x16 = a; y16 = b; sm16 = sm;
        @(negedge clk);
        iv16 = 1'b0; x16 = $urandom; y16 = $urandom; sm16 = $urandom;
        lat = 0;
        while (!ov16 && lat < 50) begin @(negedge clk); lat++; end
        prod = o16;
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] held;
        int lat;

        rst_n = 1'b0;
        iv16 = 0; or16 = 0; x16 = 0; y16 = 0; sm16 = 0;
        iv8 = 0;  or8 = 0;  x8 = 0;  y8 = 0;  sm8 = 0;
        #12;
        check("rst_in_ready", 64'(ir16), 64'd1);
        check("rst_out_valid", 64'(ov16), 64'd0);
        check("rst_out_o", 64'(o16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op16(16'hFFFD, 16'h0007, 1'b1, p, lat);
        check("neg3x7", 64'(p), 64'hFFFFFFEB);
        check("latency", 64'(lat), 64'd9);
        op16(16'hFFFF, 16'hFFFF, 1'b0, p, lat);
        check("ffff_unsigned", 64'(p), 64'hFFFE0001);
        check("latency_unsigned", 64'(lat), 64'd9);
        op16(16'hFFFF, 16'hFFFF, 1'b1, p, lat);
        check("ffff_signed", 64'(p), 64'h00000001);
        op16(16'h8000, 16'h8000, 1'b1, p, lat);
        check("min_x_min", 64'(p), 64'h40000000);
        op16(16'h8000, 16'h7FFF, 1'b1, p, lat);
        check("min_x_max", 64'(p), 64'hC0008000);
        op16(16'h0000, 16'h1234, 1'b1, p, lat);
        check("zero_x", 64'(p), 64'd0);
        check("out_o_kept", 64'(o16), 64'd0);

        // Back-pressure in DONE with a competing in_valid
        iv16 = 1'b1; x16 = 16'd100; y16 = 16'd7; sm16 = 1'b0;
        @(negedge clk);
        x16 = 16'd3; y16 = 16'd3;
        lat = 0;
        while (!ov16 && lat < 50) begin @(negedge clk); lat++; end
        held = o16;
        check("bp_value", 64'(held), 64'd700);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(ov16), 64'd1);
            check("bp_out_stable", 64'(o16), 64'(held));
            check("bp_in_ready", 64'(ir16), 64'd0);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("bp_release_valid", 64'(ov16), 64'd0);
        check("bp_release_ready", 64'(ir16), 64'd1);
        check("bp_kept_after", 64'(o16), 64'd700);

        // Reset during BUSY cycle 4 aborts the operation
        iv16 = 1'b1; x16 = 16'h1234; y16 = 16'h5678; sm16 = 1'b0;
        @(negedge clk);
        iv16 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(ov16), 64'd0);
        check("abort_out_o", 64'(o16), 64'd0);
        check("abort_in_ready", 64'(ir16), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op16(16'd5, 16'd6, 1'b0, p, lat);
        check("after_abort", 64'(p), 64'd30);

        // Randomized back-to-back traffic on both widths concurrently
        fork
            begin
                logic [15:0] a, b;
                logic sm;
                int g, l;
                for (int t = 0; t < 2000; t++) begin
                    a = $urandom; b = $urandom; sm = $urandom;
                    if (t % 7 == 0) a = 16'h8000;
                    if (t % 11 == 0) b = 16'hFFFF;
                    iv16 = 1'b1; x16 = a; y16 = b; sm16 = sm;
                    @(negedge clk);
                    iv16 = 1'b0;
                    l = 0;
                    while (!ov16 && l < 50) begin @(negedge clk); l++; end
                    check("r16_latency", 64'(l), 64'd9);
                    check("r16_prod", 64'(o16), ref_mul(32'(a), 32'(b), sm, 16));
                    g = 0;
                    do begin
                        or16 = $urandom;
                        @(negedge clk);
                        g++;
                    end while (ov16 && g < 200);
                    or16 = 1'b0;
                    if (g == 200) check("r16_drain_timeout", 64'(g), 64'd0);
                end
            end
            begin
                logic [7:0] a, b;
                logic sm;
                int g, l;
                for (int t = 0; t < 2000; t++) begin
                    a = $urandom; b = $urandom; sm = $urandom;
                    if (t % 5 == 0) a = 8'h80;
                    iv8 = 1'b1; x8 = a; y8 = b; sm8 = sm;
                    @(negedge clk);
                    iv8 = 1'b0;
                    l = 0;
                    while (!ov8 && l < 50) begin @(negedge clk); l++; end
                    check("r8_latency", 64'(l), 64'd5);
                    check("r8_prod", 64'(o8), ref_mul(32'(a), 32'(b), sm, 8));
                    g = 0;
                    do begin
                        or8 = $urandom;
                        @(negedge clk);
                        g++;
                    end while (ov8 && g < 200);
                    or8 = 1'b0;
                    if (g == 200) check("r8_drain_timeout", 64'(g), 64'd0);
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
